// File: rtl/mealy_fsm_pkg.sv
// rtl/mealy_fsm_pkg.sv - shared constants, table-entry type and index packing for mealy_fsm_prog
//
// Purpose : default parameter values for the programmable Mealy FSM, the
//           {next, out} table-entry layout at default widths, and the
//           {state, in} lookup-index packing helper.
// Ports   : none (package)

package mealy_fsm_pkg;

  localparam int DEF_STATE_W     = 3;
  localparam int DEF_IN_W        = 2;
  localparam int DEF_OUT_W       = 3;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RESET_STATE = 0;

  typedef struct packed {
    logic [DEF_STATE_W-1:0] nxt;
    logic [DEF_OUT_W-1:0]   out;
  } tbl_entry_t;

  function automatic logic [DEF_STATE_W+DEF_IN_W-1:0] pack_idx(
    input logic [DEF_STATE_W-1:0] st,
    input logic [DEF_IN_W-1:0]    sym
  );
    return {st, sym};
  endfunction

endpackage

// File: rtl/fsm_table_ram.sv
// rtl/fsm_table_ram.sv - transition/output table register file for mealy_fsm_prog
//
// Purpose : 2^(STATE_W+IN_W) entries of {next, out}. One synchronous write
//           port, one asynchronous read port. Reset makes every row a
//           self-loop (next = row state) with out = 0.
// Ports   : clk, rst (sync, active-low)
//           we, waddr, wnext, wout : write port, applied at the clock edge
//           raddr -> rnext, rout   : combinational read port

module fsm_table_ram
  import mealy_fsm_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [STATE_W+IN_W-1:0] waddr,
  input  logic [STATE_W-1:0]      wnext,
  input  logic [OUT_W-1:0]        wout,
  input  logic [STATE_W+IN_W-1:0] raddr,
  output logic [STATE_W-1:0]      rnext,
  output logic [OUT_W-1:0]        rout
);

  localparam int DEPTH = 1 << (STATE_W + IN_W);

  typedef struct packed {
    logic [STATE_W-1:0] nxt;
    logic [OUT_W-1:0]   out;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = '{nxt: wnext, out: wout};
    end
  end

  // Row state is the upper STATE_W bits of the index, so each entry
  // points back at its own state after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{nxt: STATE_W'(i >> IN_W), out: '0};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read reflects registered contents only: a same-cycle write is not seen.
  assign rnext = mem_q[raddr].nxt;
  assign rout  = mem_q[raddr].out;

endmodule

// File: rtl/mealy_fsm_prog.sv
// rtl/mealy_fsm_prog.sv - runtime-programmable Mealy state machine
//
// Purpose : Mealy FSM whose transition/output table is loaded over a config
//           port. Adds run-enable, a registered output copy and a saturating
//           count of real state changes.
// Ports   : clk, rst (sync, active-low), en (run enable), in (input symbol)
//           cfg_we, cfg_addr={state,in}, cfg_next, cfg_out : table write
//           cnt_clr : synchronous clear of trans_cnt
//           out (combinational), out_q (out delayed one cycle),
//           state (current), trans_cnt (saturating)

module mealy_fsm_prog
  import mealy_fsm_pkg::*;
#(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RESET_STATE = DEF_RESET_STATE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [IN_W-1:0]         in,
  input  logic                    cfg_we,
  input  logic [STATE_W+IN_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]        cfg_out,
  input  logic                    cnt_clr,
  output logic [OUT_W-1:0]        out,
  output logic [OUT_W-1:0]        out_q,
  output logic [STATE_W-1:0]      state,
  output logic [CNT_W-1:0]        trans_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_dly_q, out_dly_d;
  logic [CNT_W-1:0]   trans_cnt_q, trans_cnt_d;
  logic [STATE_W-1:0] tbl_next;
  logic [OUT_W-1:0]   tbl_out;
  logic               trans;

  fsm_table_ram #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wnext (cfg_next),
    .wout  (cfg_out),
    .raddr ({state_q, in}),
    .rnext (tbl_next),
    .rout  (tbl_out)
  );

  // State register (with out_q and counter)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= STATE_W'(RESET_STATE);
      out_dly_q   <= '0;
      trans_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_dly_q   <= out_dly_d;
      trans_cnt_q <= trans_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = en ? tbl_next : state_q;
    trans       = en && (tbl_next != state_q);
    trans_cnt_d = trans_cnt_q;
    if (cnt_clr) begin
      trans_cnt_d = '0;
    end else if (trans && (trans_cnt_q != {CNT_W{1'b1}})) begin
      trans_cnt_d = trans_cnt_q + 1'b1;
    end
  end

  // Output logic: disabled machine drives 0, which out_q then captures.
  always_comb begin
    out       = en ? tbl_out : '0;
    out_dly_d = out;
  end

  assign out_q     = out_dly_q;
  assign state     = state_q;
  assign trans_cnt = trans_cnt_q;

endmodule

// File: tb/tb_mealy_fsm_prog.sv
// tb/tb_mealy_fsm_prog.sv - directed self-checking bench for mealy_fsm_prog

module tb_mealy_fsm_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] in;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [2:0] cfg_next;
  logic [2:0] cfg_out;
  logic       cnt_clr;

  logic [2:0]  out, out_q, state;
  logic [15:0] trans_cnt;
  logic [2:0]  out2, out_q2, state2;
  logic [1:0]  trans_cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mealy_fsm_prog dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .cnt_clr(cnt_clr),
    .out(out), .out_q(out_q), .state(state), .trans_cnt(trans_cnt)
  );

  mealy_fsm_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .cnt_clr(cnt_clr),
    .out(out2), .out_q(out_q2), .state(state2), .trans_cnt(trans_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int st, input int oq, input int cnt, input int cnt2);
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " out_q"}, 32'(out_q), 32'(oq));
    chk({tag, " trans_cnt"}, 32'(trans_cnt), 32'(cnt));
    chk({tag, " trans_cnt2"}, 32'(trans_cnt2), 32'(cnt2));
  endtask

  task automatic cfg_write(input int addr, input int nxt, input int o);
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_next = 3'(nxt);
    cfg_out  = 3'(o);
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in = 2'd0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_next = '0; cfg_out = '0; cnt_clr = 1'b0;
    tick();
    tick();
    chk_regs("reset", 0, 0, 0, 0);
    rst = 1'b1;

    // Unconfigured: self-loop at state 0, out 0
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in = 2'(i);
      #1;
      chk("noconf out", 32'(out), 32'd0);
      tick();
      chk_regs("noconf", 0, 0, 0, 0);
    end

    // Load entries with machine stopped
    en = 1'b0;
    cfg_write(1, 3, 6);   // {0,1}
    cfg_write(2, 1, 4);   // {0,2}
    cfg_write(12, 0, 2);  // {3,0}
    cfg_write(4, 0, 5);   // {1,0}
    cfg_write(20, 6, 1);  // {5,0}
    cfg_write(3, 5, 3);   // {0,3}

    en = 1'b1; in = 2'd1;
    #1;
    chk("s1 out", 32'(out), 32'd6);
    tick();
    chk_regs("s1", 3, 6, 1, 1);

    in = 2'd0;
    #1;
    chk("s2 out", 32'(out), 32'd2);
    tick();
    chk_regs("s2", 0, 2, 2, 2);

    // Rewrite the entry being looked up: old contents govern this cycle
    in = 2'd2; cfg_we = 1'b1; cfg_addr = 5'd2; cfg_next = 3'd5; cfg_out = 3'd7;
    #1;
    chk("rbw out", 32'(out), 32'd4);
    tick();
    cfg_we = 1'b0;
    chk_regs("rbw", 1, 4, 3, 3);

    en = 1'b0; in = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold out", 32'(out), 32'd0);
      tick();
      chk_regs("hold", 1, 0, 3, 3);
    end

    en = 1'b1; in = 2'd0;
    #1;
    chk("resume out", 32'(out), 32'd5);
    tick();
    chk_regs("resume", 0, 5, 4, 3);

    in = 2'd2;
    #1;
    chk("newentry out", 32'(out), 32'd7);
    tick();
    chk_regs("newentry", 5, 7, 5, 3);

    in = 2'd1;
    #1;
    chk("selfloop out", 32'(out), 32'd0);
    tick();
    chk_regs("selfloop", 5, 0, 5, 3);

    // Clear wins over a simultaneous transition
    in = 2'd0; cnt_clr = 1'b1;
    #1;
    chk("clr out", 32'(out), 32'd1);
    tick();
    cnt_clr = 1'b0;
    chk_regs("clr", 6, 1, 0, 0);

    en = 1'b0;
    cfg_write(24, 5, 3);  // {6,0}
    en = 1'b1; in = 2'd0;
    #1;
    chk("to5 out", 32'(out), 32'd3);
    tick();
    chk_regs("to5", 5, 3, 1, 1);

    // Reset overrides en, cnt_clr-free transition and a concurrent write
    rst = 1'b0; cfg_we = 1'b1; cfg_addr = 5'd1; cfg_next = 3'd2; cfg_out = 3'd5;
    #1;
    chk("prerst out", 32'(out), 32'd1);
    tick();
    rst = 1'b1; cfg_we = 1'b0;
    chk_regs("rst2", 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      in = 2'(i);
      #1;
      chk("cleared out", 32'(out), 32'd0);
      tick();
      chk_regs("cleared", 0, 0, 0, 0);
    end

    chk("dut2 state", 32'(state2), 32'(state));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
